mdio_arbiter: RTL and testbench
===============================

# mdio_arbiter

Controller in front of the e1000 MDIO shift engine. It shares the single engine between two requesters: the host MDIC register path and an autonomous PHY link-status poller. It issues 32-bit management frames to the engine, tracks completion through the engine's done lines, and guards against a hung engine with a timeout. It also publishes link state derived from PHY status-register polls.

## Interface
Parameters:
- POLL_INTERVAL, 1000000: cycles between automatic link polls (minimum 2)
- POLL_REG, 5'd1: PHY register address polled for link status
- TIMEOUT, 8192: cycles allowed per engine transaction before abort

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- host_req  in  1  level; host holds it with host_frame until host_ack
- host_frame  in  32  MDIO frame: [31:30] ST, [29:28] OP (10 read, 01 write), [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] data
- host_ack  out  1  one-cycle completion pulse
- host_err  out  1  valid with host_ack; 1 = timeout or illegal OP
- host_rdata  out  16  read data, valid with host_ack
- poll_en  in  1  enables the link poller
- poll_phyad  in  5  PHY address to poll
- link_up  out  1  last polled status bit 2
- link_change  out  1  one-cycle pulse when link_up toggles
- busy  out  1  high from grant through COMPLETE
- eng_en  out  1  one-cycle start pulse to the engine
- eng_wdata  out  32  frame to the engine
- eng_rdata  in  16  engine read data
- eng_rd_done  in  1  engine read done; idles high, low while a read is in flight
- eng_wr_done  in  1  engine write done; idles high, low while a write is in flight

## Operation
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, COMPLETE.
- IDLE:
  - Request sources are host_req and poll_pend.
  - Both pending: grant the source not served last. The served-last flag resets to "poll".
  - One pending: grant that source.
  - The granted frame is latched into eng_wdata. State goes to ISSUE.
- Host frame with OP 00 or 11: no engine access. host_ack=1 and host_err=1 next cycle; host_rdata is unchanged. State stays IDLE.
- ISSUE: eng_en=1 for exactly one cycle, then WAIT_START.
- The active done line is selected by the latched OP: eng_rd_done for 10, eng_wr_done for 01.
- WAIT_START: wait for the active done line to go low, then WAIT_DONE.
- WAIT_DONE: wait for the active done line to return high, then COMPLETE. eng_rdata is captured on that edge.
- COMPLETE (one cycle), then IDLE. Outputs by owner:
  - Host owner: host_ack=1, host_err=0, host_rdata=captured data (writes return 16'h0000).
  - Poll owner: link_up<=data[2]; link_change=1 if the value differs from the previous link_up.
- Timeout counter clears in ISSUE and counts in WAIT_START and WAIT_DONE. When it reaches TIMEOUT, go to COMPLETE with abort:
  - Host owner: host_err=1, host_rdata=16'hFFFF.
  - Poll owner: link_up<=0; link_change pulses if link_up was 1.
- Poll frame: {2'b01, 2'b10, poll_phyad, POLL_REG, 2'b11, 16'hFFFF}.
- Poll timer:
  - Counts while poll_en=1. At POLL_INTERVAL-1 it sets poll_pend and wraps to 0.
  - poll_pend clears when the poll is granted.
  - poll_en=0 holds the timer at 0 and clears an ungranted poll_pend. An in-flight poll runs to completion and still updates link_up.
- host_req dropping before grant withdraws the request. Dropping after grant is ignored; the transaction completes and acks.
- eng_wdata holds stable from grant through COMPLETE.

## Timing
- Reset values: eng_en 0, eng_wdata 0, host_ack 0, host_err 0, host_rdata 0, link_up 0, link_change 0, busy 0. FSM resets to IDLE, timers to 0.
- Reset mid-transaction returns to IDLE immediately. No ack is issued.
- Grant to eng_en: 1 cycle. host_ack comes 1 cycle after the done line rises.
- Overhead beyond engine time is 4 cycles per transaction (IDLE, ISSUE, WAIT detection, COMPLETE).
- The first poll after reset or poll_en rise is requested POLL_INTERVAL cycles later.
- host_req and the poll timer expiring in the same cycle: the arbitration rule applies. The losing source is served next transaction.
- No new grant while busy=1. A host_req held continuously is re-granted only after the ack cycle.

## Test plan
- Host read, frame 32'h6xxx_xxxx (OP=10), engine model returns 16'h796D -> one eng_en pulse; host_ack with host_err=0, host_rdata=16'h796D.
- Host write, OP=01 -> eng_wr_done low then high; host_ack, host_err=0, host_rdata=16'h0000; eng_wd line for reads untouched.
- POLL_INTERVAL=100, poll_en=1, engine returns bit2=1 then bit2=0 -> link_up goes 1 then 0; link_change pulses once at each edge; poll frame REGAD=1.
- host_req held and poll expiring together repeatedly -> grants alternate host, poll, host, poll; no starvation.
- Engine never drops done, TIMEOUT=64 -> abort after 64 cycles; host_ack with host_err=1, host_rdata=16'hFFFF; FSM back in IDLE.
- OP=11 frame -> host_ack with host_err=1 one cycle after request; eng_en never asserted. rst_n pulsed during WAIT_DONE -> all outputs at reset values and no ack.

Source files
------------

// File: rtl/mdio_arbiter.sv
// MDIO arbiter: shares one MDIO shift engine between the host MDIC path and
// an autonomous link-status poller, with a per-transaction hang timeout.
//
// state      | meaning
// IDLE       | arbitrate host_req / poll_pend, latch granted frame
// ISSUE      | one-cycle eng_en start pulse
// WAIT_START | wait for the active done line to drop
// WAIT_DONE  | wait for the active done line to return high
// COMPLETE   | ack host or update link state, then back to IDLE
module mdio_arbiter #(
    parameter int         POLL_INTERVAL = 1000000,
    parameter logic [4:0] POLL_REG      = 5'd1,
    parameter int         TIMEOUT       = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_req,
    input  logic [31:0] host_frame,
    output logic        host_ack,
    output logic        host_err,
    output logic [15:0] host_rdata,
    input  logic        poll_en,
    input  logic [4:0]  poll_phyad,
    output logic        link_up,
    output logic        link_change,
    output logic        busy,
    output logic        eng_en,
    output logic [31:0] eng_wdata,
    input  logic [15:0] eng_rdata,
    input  logic        eng_rd_done,
    input  logic        eng_wr_done
);

    localparam int PW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_START, WAIT_DONE, COMPLETE
    } state_t;

    state_t          state, state_nxt;
    logic            owner_host;
    logic            last_host;
    logic [TW-1:0]   tmo_cnt;
    logic [PW-1:0]   poll_cnt;
    logic            poll_pend;
    logic            host_cand, poll_cand, op_legal;
    logic            grant_host, grant_poll, grant_bad;
    logic            done_ok, tmo_hit, active_done, link_new;

    assign eng_en = (state == ISSUE);
    assign busy   = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Arbitration and next-state; a host still in its ack cycle is not re-granted
    always_comb begin
        state_nxt   = state;
        grant_host  = 1'b0;
        grant_poll  = 1'b0;
        grant_bad   = 1'b0;
        done_ok     = 1'b0;
        tmo_hit     = 1'b0;
        host_cand   = host_req && !host_ack;
        poll_cand   = poll_pend && poll_en;
        op_legal    = host_frame[29] ^ host_frame[28];
        active_done = eng_wdata[29] ? eng_rd_done : eng_wr_done;
        case (state)
            IDLE: begin
                if (host_cand && (!poll_cand || !last_host)) begin
                    if (op_legal) begin
                        grant_host = 1'b1;
                        state_nxt  = ISSUE;
                    end else begin
                        grant_bad  = 1'b1;
                    end
                end else if (poll_cand) begin
                    grant_poll = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT_START;
            WAIT_START: begin
                if (!active_done) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = COMPLETE;
                end
            end
            WAIT_DONE: begin
                if (active_done) begin
                    done_ok   = 1'b1;
                    state_nxt = COMPLETE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = COMPLETE;
                end
            end
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping: owner, served-last flag and the frame held for the engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_host <= 1'b0;
            last_host  <= 1'b0;
            eng_wdata  <= 32'h0;
        end else if (grant_host) begin
            owner_host <= 1'b1;
            last_host  <= 1'b1;
            eng_wdata  <= host_frame;
        end else if (grant_poll) begin
            owner_host <= 1'b0;
            last_host  <= 1'b0;
            eng_wdata  <= {2'b01, 2'b10, poll_phyad, POLL_REG, 2'b11, 16'hFFFF};
        end else if (grant_bad) begin
            last_host  <= 1'b1;
        end
    end

    // Transaction timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                           tmo_cnt <= '0;
        else if (state == ISSUE)                              tmo_cnt <= '0;
        else if (state == WAIT_START || state == WAIT_DONE)   tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Poll interval timer; a new expiry wins over a same-cycle grant clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else if (!poll_en) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else begin
            poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
            if (poll_cnt == POLL_LAST) poll_pend <= 1'b1;
            else if (grant_poll)       poll_pend <= 1'b0;
        end
    end

    // Host response; illegal OPs are answered straight from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= 16'h0;
        end else begin
            host_ack <= 1'b0;
            host_err <= 1'b0;
            if (grant_bad) begin
                host_ack <= 1'b1;
                host_err <= 1'b1;
            end else if ((done_ok || tmo_hit) && owner_host) begin
                host_ack   <= 1'b1;
                host_err   <= tmo_hit;
                host_rdata <= tmo_hit ? 16'hFFFF : (eng_wdata[29] ? eng_rdata : 16'h0000);
            end
        end
    end

    assign link_new = tmo_hit ? 1'b0 : eng_rdata[2];

    // Link state from poll results; an aborted poll reports link down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_up     <= 1'b0;
            link_change <= 1'b0;
        end else begin
            link_change <= 1'b0;
            if ((done_ok || tmo_hit) && !owner_host) begin
                link_up     <= link_new;
                link_change <= link_new ^ link_up;
            end
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter: engine model, host scoreboard,
// poller, arbitration fairness, timeout and mid-transaction reset.
module tb_mdio_arbiter;

    localparam logic [31:0] RD_FRAME   = {2'b01, 2'b10, 5'd3, 5'd3, 2'b10, 16'h0000};
    localparam logic [31:0] WR_FRAME   = {2'b01, 2'b01, 5'd3, 5'd4, 2'b10, 16'hA5A5};
    localparam logic [31:0] BAD_FRAME  = {2'b01, 2'b11, 5'd3, 5'd3, 2'b10, 16'h0000};
    localparam logic [31:0] POLL_FRAME = {2'b01, 2'b10, 5'd9, 5'd1, 2'b11, 16'hFFFF};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_req;
    logic [31:0] host_frame;
    logic        host_ack, host_err;
    logic [15:0] host_rdata;
    logic        poll_en;
    logic [4:0]  poll_phyad;
    logic        link_up, link_change, busy, eng_en;
    logic [31:0] eng_wdata;
    logic [15:0] eng_rdata;
    logic        eng_rd_done, eng_wr_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_count = 0, ack_count = 0, chg_count = 0, en_double = 0;
    int last_en_cyc = 0, rise_cyc = 0;
    int eng_start = 1, eng_busy = 2;
    logic        prev_en = 1'b0;
    logic        hang = 1'b0;
    logic [15:0] poll_status = 16'h0;
    logic [15:0] host_data = 16'h0;
    logic [31:0] eng_log[$];
    logic [16:0] exp_q[$];

    mdio_arbiter #(.POLL_INTERVAL(100), .POLL_REG(5'd1), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_frame(host_frame),
        .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
        .poll_en(poll_en), .poll_phyad(poll_phyad),
        .link_up(link_up), .link_change(link_change), .busy(busy),
        .eng_en(eng_en), .eng_wdata(eng_wdata), .eng_rdata(eng_rdata),
        .eng_rd_done(eng_rd_done), .eng_wr_done(eng_wr_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor
    always @(negedge clk) begin
        if (eng_en === 1'b1) begin
            en_count <= en_count + 1;
            last_en_cyc <= cyc;
            eng_log.push_back(eng_wdata);
            if (prev_en) en_double <= en_double + 1;
        end
        prev_en <= (eng_en === 1'b1);
        if (host_ack === 1'b1) ack_count <= ack_count + 1;
        if (link_change === 1'b1) chg_count <= chg_count + 1;
    end

    // Engine model: drops the OP-selected done line, then raises it with data
    initial begin
        logic        rd;
        logic [31:0] fr;
        eng_rd_done = 1'b1;
        eng_wr_done = 1'b1;
        eng_rdata   = 16'h0;
        forever begin
            @(negedge clk);
            if (eng_en === 1'b1 && !hang) begin
                fr = eng_wdata;
                rd = (fr[29:28] == 2'b10);
                repeat (eng_start) @(negedge clk);
                if (rd) eng_rd_done = 1'b0;
                else    eng_wr_done = 1'b0;
                repeat (eng_busy) @(negedge clk);
                eng_rdata   = (fr == POLL_FRAME) ? poll_status : host_data;
                eng_rd_done = 1'b1;
                eng_wr_done = 1'b1;
                rise_cyc    = cyc;
            end
        end
    end

    task automatic do_host(input logic [31:0] frame, input logic e_err, input logic [15:0] e_rd,
                           input string nm, output int req_c, output int ack_c);
        logic        got;
        logic [16:0] e;
        exp_q.push_back({e_err, e_rd});
        @(negedge clk);
        host_frame = frame;
        host_req   = 1'b1;
        req_c      = cyc;
        ack_c      = -1;
        got        = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (host_ack === 1'b1) begin
                got   = 1'b1;
                ack_c = cyc;
            end
        end
        host_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_ack: no host_ack within 300 cycles, required one", nm);
        end else begin
            checks++;
            if ({host_err, host_rdata} !== e) begin
                failures++;
                $display("FAIL %s_resp: got err=%0b rdata=%h, required err=%0b rdata=%h",
                         nm, host_err, host_rdata, e[16], e[15:0]);
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        logic ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_idle: busy=%0b after 200 cycles, required 0", nm, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; host_req = 1'b0; host_frame = 32'h0; poll_en = 1'b0; poll_phyad = 5'd9;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({eng_en, host_ack, host_err, link_up, link_change, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctl: got en/ack/err/link/chg/busy=%b, required 000000",
                     {eng_en, host_ack, host_err, link_up, link_change, busy});
        end
        checks++;
        if (eng_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_wdata: got %h, required 00000000", eng_wdata);
        end
        checks++;
        if (host_rdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h, required 0000", host_rdata);
        end
    endtask

    task automatic test_host_read();
        int e0, r, a;
        host_data = 16'h796D;
        e0 = en_count;
        do_host(RD_FRAME, 1'b0, 16'h796D, "host_read", r, a);
        checks++;
        if (en_count - e0 != 1) begin
            failures++;
            $display("FAIL read_en_count: got %0d pulses, required 1", en_count - e0);
        end
        checks++;
        if (last_en_cyc - r != 1) begin
            failures++;
            $display("FAIL read_grant_lat: got %0d cycles, required 1", last_en_cyc - r);
        end
        checks++;
        if (a - rise_cyc != 1) begin
            failures++;
            $display("FAIL read_ack_lat: got %0d cycles after done rise, required 1", a - rise_cyc);
        end
        checks++;
        if (eng_log[eng_log.size()-1] !== RD_FRAME) begin
            failures++;
            $display("FAIL read_frame: got %h, required %h", eng_log[eng_log.size()-1], RD_FRAME);
        end
    endtask

    task automatic test_host_write();
        int e0, r, a;
        e0 = en_count;
        do_host(WR_FRAME, 1'b0, 16'h0000, "host_write", r, a);
        checks++;
        if (en_count - e0 != 1) begin
            failures++;
            $display("FAIL write_en_count: got %0d pulses, required 1", en_count - e0);
        end
        checks++;
        if (eng_log[eng_log.size()-1] !== WR_FRAME) begin
            failures++;
            $display("FAIL write_frame: got %h, required %h", eng_log[eng_log.size()-1], WR_FRAME);
        end
    endtask

    task automatic test_illegal_op();
        int e0, r, a;
        e0 = en_count;
        do_host(BAD_FRAME, 1'b1, 16'h0000, "illegal_op", r, a);
        checks++;
        if (a - r != 1) begin
            failures++;
            $display("FAIL illegal_lat: got %0d cycles, required 1", a - r);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (en_count != e0) begin
            failures++;
            $display("FAIL illegal_en: got %0d engine starts, required 0", en_count - e0);
        end
    endtask

    task automatic test_poll();
        int c0, s, d;
        logic got;
        logic [31:0] fr;
        poll_status = 16'h0004;
        c0 = chg_count;
        @(negedge clk);
        poll_en = 1'b1;
        s = cyc;
        got = 1'b0; d = -1; fr = 32'h0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (eng_en === 1'b1) begin got = 1'b1; d = cyc - s; fr = eng_wdata; end
        end
        checks++;
        if (d != 101) begin
            failures++;
            $display("FAIL poll_first_lat: got %0d cycles, required 101", d);
        end
        checks++;
        if (fr !== POLL_FRAME) begin
            failures++;
            $display("FAIL poll_frame: got %h, required %h", fr, POLL_FRAME);
        end
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (link_change === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || link_up !== 1'b1) begin
            failures++;
            $display("FAIL poll_link_rise: got change=%0b link_up=%0b, required 1 1", got, link_up);
        end
        poll_status = 16'hFFFB;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (link_change === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || link_up !== 1'b0) begin
            failures++;
            $display("FAIL poll_link_fall: got change=%0b link_up=%0b, required 1 0", got, link_up);
        end
        repeat (120) @(negedge clk);
        checks++;
        if (chg_count - c0 != 2 || link_up !== 1'b0) begin
            failures++;
            $display("FAIL poll_change_count: got %0d pulses link_up=%0b, required 2 0",
                     chg_count - c0, link_up);
        end
        poll_en = 1'b0;
        wait_idle("poll");
    endtask

    task automatic test_alternation();
        int idx0, polls, consec;
        logic prev_poll, p;
        poll_status = 16'h0;
        @(negedge clk);
        poll_en = 1'b1;
        repeat (100) @(negedge clk);
        idx0 = eng_log.size();
        host_frame = RD_FRAME;
        host_req   = 1'b1;
        repeat (360) @(negedge clk);
        host_req = 1'b0;
        poll_en  = 1'b0;
        wait_idle("alternation");
        polls = 0; consec = 0; prev_poll = 1'b0;
        for (int i = idx0; i < eng_log.size(); i++) begin
            p = (eng_log[i] == POLL_FRAME);
            if (p) polls++;
            if (p && prev_poll) consec++;
            prev_poll = p;
        end
        checks++;
        if (eng_log.size() < idx0 + 2) begin
            failures++;
            $display("FAIL alt_grants: got %0d grants, required at least 2", eng_log.size() - idx0);
        end else begin
            checks++;
            if (eng_log[idx0] !== RD_FRAME || eng_log[idx0+1] !== POLL_FRAME) begin
                failures++;
                $display("FAIL alt_tie_order: got %h then %h, required %h then %h",
                         eng_log[idx0], eng_log[idx0+1], RD_FRAME, POLL_FRAME);
            end
        end
        checks++;
        if (polls < 3 || consec != 0) begin
            failures++;
            $display("FAIL alt_fairness: got %0d polls %0d back-to-back, required >=3 and 0",
                     polls, consec);
        end
    endtask

    task automatic test_timeout();
        int r, a;
        hang = 1'b1;
        do_host(RD_FRAME, 1'b1, 16'hFFFF, "timeout", r, a);
        checks++;
        if (a - last_en_cyc != 65) begin
            failures++;
            $display("FAIL timeout_lat: got %0d cycles from eng_en, required 65", a - last_en_cyc);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle: got busy=%0b, required 0", busy);
        end
        hang = 1'b0;
    endtask

    task automatic test_reset_mid();
        int a0;
        logic got = 1'b0;
        eng_busy = 10;
        @(negedge clk);
        host_frame = RD_FRAME;
        host_req   = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (eng_rd_done === 1'b0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rstmid_start: engine never started, required start");
        end
        repeat (2) @(negedge clk);
        a0 = ack_count;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({eng_en, host_ack, host_err, link_up, link_change, busy} !== 6'b0 ||
            eng_wdata !== 32'h0 || host_rdata !== 16'h0) begin
            failures++;
            $display("FAIL rstmid_values: got ctl=%b wdata=%h rdata=%h, required 000000 00000000 0000",
                     {eng_en, host_ack, host_err, link_up, link_change, busy}, eng_wdata, host_rdata);
        end
        @(negedge clk);
        host_req = 1'b0;
        rst_n    = 1'b1;
        repeat (25) @(negedge clk);
        checks++;
        if (ack_count != a0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_ack: got %0d acks busy=%0b, required 0 0", ack_count - a0, busy);
        end
        eng_busy = 2;
    endtask

    initial begin
        test_reset();
        test_host_read();
        test_host_write();
        test_illegal_op();
        test_poll();
        test_alternation();
        test_timeout();
        test_reset_mid();
        checks++;
        if (en_double != 0) begin
            failures++;
            $display("FAIL eng_en_width: got %0d multi-cycle pulses, required 0", en_double);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
